gelato_warp_split_table: RTL and testbench

Per-warp table of divergent execution paths (split entries). Each entry holds a PC and an active-thread mask. The table picks one ready entry per cycle, round-robin, and drives the select-PC channel to the split table / fetch path. It consumes update-PC responses (next PC, stall, exit) and writeback releases, and it allocates new entries on branch splits. Sits directly upstream of the split table; one instance per warp.

---
 rtl/gelato_warp_split_table.sv | 176 +++++++++++++++++
 tb/tb_gelato_warp_split_table.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gelato_warp_split_table.sv
// Per-warp split table: round-robin pick of one READY entry per cycle onto a registered select pulse.
// One cycle from state to select_*; split_ready is combinational, and a split issued while it is low is dropped.
module gelato_warp_split_table #(
  parameter int NUM_SPLIT  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int THREAD_NUM = 32,
  parameter int NUM_W      = $clog2(NUM_SPLIT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  launch_valid,
  input  logic [ADDR_WIDTH-1:0] launch_pc,
  input  logic [THREAD_NUM-1:0] launch_mask,
  output logic                  select_valid,
  output logic [ADDR_WIDTH-1:0] select_pc,
  output logic [NUM_W-1:0]      select_split_table_num,
  output logic [THREAD_NUM-1:0] select_mask,
  input  logic                  update_valid,
  input  logic                  update_stall,
  input  logic                  update_exit,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic [NUM_W-1:0]      update_split_table_num,
  input  logic                  split_valid,
  input  logic [NUM_W-1:0]      split_num,
  input  logic [ADDR_WIDTH-1:0] split_taken_pc,
  input  logic [THREAD_NUM-1:0] split_taken_mask,
  output logic                  split_ready,
  input  logic                  wb_valid,
  input  logic [NUM_W-1:0]      wb_split_table_num,
  output logic                  warp_done
);

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_INFLIGHT = 2'd1,
    ST_STALLED  = 2'd2
  } status_t;

  logic [NUM_SPLIT-1:0]  ent_valid, ent_valid_nxt;
  logic [ADDR_WIDTH-1:0] ent_pc       [NUM_SPLIT];
  logic [ADDR_WIDTH-1:0] ent_pc_nxt   [NUM_SPLIT];
  logic [THREAD_NUM-1:0] ent_mask     [NUM_SPLIT];
  logic [THREAD_NUM-1:0] ent_mask_nxt [NUM_SPLIT];
  status_t               ent_st       [NUM_SPLIT];
  status_t               ent_st_nxt   [NUM_SPLIT];
  logic [NUM_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic                  launched;

  logic                  free_found;
  logic [NUM_W-1:0]      free_idx;
  logic                  split_go;
  logic                  sel_found;
  logic [NUM_W-1:0]      sel_idx;
  logic [NUM_W-1:0]      cand;
  logic [NUM_SPLIT-1:0]  eligible;

  assign split_ready = ~&ent_valid;

  always_comb begin : find_free
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_SPLIT; i++) begin
      if (!free_found && !ent_valid[i]) begin
        free_found = 1'b1;
        free_idx   = NUM_W'(i);
      end
    end
  end

  // A split with an empty taken mask changes nothing, so it does not block selection of its parent.
  assign split_go = split_valid && free_found && ent_valid[split_num] &&
                    (split_taken_mask != '0);

  always_comb begin : pick
    eligible  = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_SPLIT; i++) begin
      eligible[i] = ent_valid[i] && (ent_st[i] == ST_READY) &&
                    !(split_go && (split_num == NUM_W'(i)));
    end
    for (int k = 0; k < NUM_SPLIT; k++) begin
      cand = rr_ptr + NUM_W'(k);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin : next_state
    ent_valid_nxt = ent_valid;
    ent_pc_nxt    = ent_pc;
    ent_mask_nxt  = ent_mask;
    ent_st_nxt    = ent_st;
    rr_ptr_nxt    = rr_ptr;
    if (launch_valid) begin
      ent_valid_nxt = '0;
      for (int i = 0; i < NUM_SPLIT; i++) ent_st_nxt[i] = ST_READY;
      ent_valid_nxt[0] = 1'b1;
      ent_pc_nxt[0]    = launch_pc;
      ent_mask_nxt[0]  = launch_mask;
      rr_ptr_nxt       = '0;
    end else begin
      // Same-entry events are applied in sequence: split, then update, then writeback.
      if (split_go) begin
        if (split_taken_mask == ent_mask[split_num]) begin
          ent_pc_nxt[split_num] = split_taken_pc;
        end else begin
          ent_valid_nxt[free_idx] = 1'b1;
          ent_pc_nxt[free_idx]    = split_taken_pc;
          ent_mask_nxt[free_idx]  = split_taken_mask;
          ent_st_nxt[free_idx]    = ST_READY;
          ent_mask_nxt[split_num] = ent_mask[split_num] & ~split_taken_mask;
        end
      end
      if (update_valid && ent_valid_nxt[update_split_table_num] &&
          (ent_st_nxt[update_split_table_num] == ST_INFLIGHT)) begin
        if (update_exit) begin
          ent_valid_nxt[update_split_table_num] = 1'b0;
        end else begin
          ent_pc_nxt[update_split_table_num] = update_pc;
          ent_st_nxt[update_split_table_num] = update_stall ? ST_STALLED : ST_READY;
        end
      end
      if (wb_valid && ent_valid_nxt[wb_split_table_num] &&
          (ent_st_nxt[wb_split_table_num] == ST_STALLED)) begin
        ent_st_nxt[wb_split_table_num] = ST_READY;
      end
      if (sel_found) begin
        ent_st_nxt[sel_idx] = ST_INFLIGHT;
        rr_ptr_nxt          = sel_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid              <= '0;
      for (int i = 0; i < NUM_SPLIT; i++) begin
        ent_pc[i]   <= '0;
        ent_mask[i] <= '0;
        ent_st[i]   <= ST_READY;
      end
      rr_ptr                 <= '0;
      launched               <= 1'b0;
      warp_done              <= 1'b0;
      select_valid           <= 1'b0;
      select_pc              <= '0;
      select_split_table_num <= '0;
      select_mask            <= '0;
    end else begin
      ent_valid <= ent_valid_nxt;
      for (int i = 0; i < NUM_SPLIT; i++) begin
        ent_pc[i]   <= ent_pc_nxt[i];
        ent_mask[i] <= ent_mask_nxt[i];
        ent_st[i]   <= ent_st_nxt[i];
      end
      rr_ptr    <= rr_ptr_nxt;
      launched  <= launched | launch_valid;
      warp_done <= (launched | launch_valid) && (ent_valid_nxt == '0);
      if (launch_valid) begin
        select_valid <= 1'b0;
      end else begin
        select_valid <= sel_found;
        if (sel_found) begin
          select_pc              <= ent_pc[sel_idx];
          select_split_table_num <= sel_idx;
          select_mask            <= ent_mask[sel_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_gelato_warp_split_table.sv
// Randomized + directed bench for gelato_warp_split_table with a reference model and select-channel scoreboard.
module tb_gelato_warp_split_table;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        launch_valid = 1'b0;
  logic [31:0] launch_pc = '0;
  logic [31:0] launch_mask = '0;
  logic        select_valid;
  logic [31:0] select_pc;
  logic [1:0]  select_split_table_num;
  logic [31:0] select_mask;
  logic        update_valid = 1'b0;
  logic        update_stall = 1'b0;
  logic        update_exit = 1'b0;
  logic [31:0] update_pc = '0;
  logic [1:0]  update_split_table_num = '0;
  logic        split_valid = 1'b0;
  logic [1:0]  split_num = '0;
  logic [31:0] split_taken_pc = '0;
  logic [31:0] split_taken_mask = '0;
  logic        split_ready;
  logic        wb_valid = 1'b0;
  logic [1:0]  wb_split_table_num = '0;
  logic        warp_done;

  gelato_warp_split_table #(.NUM_SPLIT(NS), .ADDR_WIDTH(32), .THREAD_NUM(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .launch_valid(launch_valid), .launch_pc(launch_pc), .launch_mask(launch_mask),
    .select_valid(select_valid), .select_pc(select_pc),
    .select_split_table_num(select_split_table_num), .select_mask(select_mask),
    .update_valid(update_valid), .update_stall(update_stall), .update_exit(update_exit),
    .update_pc(update_pc), .update_split_table_num(update_split_table_num),
    .split_valid(split_valid), .split_num(split_num), .split_taken_pc(split_taken_pc),
    .split_taken_mask(split_taken_mask), .split_ready(split_ready),
    .wb_valid(wb_valid), .wb_split_table_num(wb_split_table_num),
    .warp_done(warp_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] pc;
    int          num;
    logic [31:0] mask;
    bit          done;
  } exp_t;

  exp_t expq[$];
  bit   mon_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // Reference table: status 0 = ready, 1 = waiting for update, 2 = waiting for writeback.
  bit          m_v    [NS];
  logic [31:0] m_pc   [NS];
  logic [31:0] m_mask [NS];
  int          m_st   [NS];
  int          m_rr;
  bit          m_launched;
  logic [31:0] m_spc, m_smask;
  int          m_snum;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int live_count();
    int n = 0;
    for (int i = 0; i < NS; i++) if (m_v[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_v[i] = 0; m_pc[i] = '0; m_mask[i] = '0; m_st[i] = 0;
    end
    m_rr = 0; m_launched = 0; m_spc = '0; m_smask = '0; m_snum = 0;
  endtask

  task automatic model_step(output exp_t e);
    int  f;
    int  pick;
    bit  touched;
    int  p;
    e.v = 0;
    if (launch_valid) begin
      for (int i = 0; i < NS; i++) m_v[i] = 0;
      m_v[0] = 1; m_pc[0] = launch_pc; m_mask[0] = launch_mask; m_st[0] = 0;
      m_rr = 0; m_launched = 1;
    end else begin
      f = -1;
      for (int i = NS - 1; i >= 0; i--) if (!m_v[i]) f = i;
      p = int'(split_num);
      touched = split_valid && (f >= 0) && m_v[p] && (split_taken_mask != 0);
      pick = -1;
      for (int k = NS - 1; k >= 0; k--) begin
        int i;
        i = (m_rr + k) % NS;
        if (m_v[i] && m_st[i] == 0 && !(touched && i == p)) pick = i;
      end
      if (pick >= 0) begin
        e.v = 1; m_spc = m_pc[pick]; m_smask = m_mask[pick]; m_snum = pick;
      end
      if (touched) begin
        if (split_taken_mask == m_mask[p]) m_pc[p] = split_taken_pc;
        else begin
          m_v[f] = 1; m_pc[f] = split_taken_pc; m_mask[f] = split_taken_mask; m_st[f] = 0;
          m_mask[p] = m_mask[p] & ~split_taken_mask;
        end
      end
      p = int'(update_split_table_num);
      if (update_valid && m_v[p] && m_st[p] == 1) begin
        if (update_exit) m_v[p] = 0;
        else begin m_pc[p] = update_pc; m_st[p] = update_stall ? 2 : 0; end
      end
      p = int'(wb_split_table_num);
      if (wb_valid && m_v[p] && m_st[p] == 2) m_st[p] = 0;
      if (pick >= 0) begin m_st[pick] = 1; m_rr = (pick + 1) % NS; end
    end
    e.pc = m_spc; e.mask = m_smask; e.num = m_snum;
    e.done = m_launched && (live_count() == 0);
  endtask

  // One clock of stimulus: inputs are already set by the caller at a negedge.
  task automatic step();
    exp_t e;
    chk("split_ready", {31'd0, split_ready}, {31'd0, live_count() < NS});
    model_step(e);
    expq.push_back(e);
    mon_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    launch_valid = 0; update_valid = 0; split_valid = 0; wb_valid = 0;
    update_stall = 0; update_exit = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (mon_en) begin
      if (expq.size() == 0) begin
        chk("scoreboard_empty", {31'd0, select_valid}, 32'd0);
      end else begin
        e = expq.pop_front();
        chk("select_valid", {31'd0, select_valid}, {31'd0, e.v});
        chk("select_pc", select_pc, e.pc);
        chk("select_num", {30'd0, select_split_table_num}, e.num);
        chk("select_mask", select_mask, e.mask);
        chk("warp_done", {31'd0, warp_done}, {31'd0, e.done});
      end
    end
  end

  task automatic do_update(input int n, input logic [31:0] pc, input bit stall, input bit ex);
    update_valid = 1; update_split_table_num = 2'(n); update_pc = pc;
    update_stall = stall; update_exit = ex;
  endtask

  task automatic do_split(input int n, input logic [31:0] pc, input logic [31:0] m);
    split_valid = 1; split_num = 2'(n); split_taken_pc = pc; split_taken_mask = m;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, select_valid}, 32'd0);
    chk({tag, "_pc"}, select_pc, 32'd0);
    chk({tag, "_num"}, {30'd0, select_split_table_num}, 32'd0);
    chk({tag, "_mask"}, select_mask, 32'd0);
    chk({tag, "_done"}, {31'd0, warp_done}, 32'd0);
    chk({tag, "_split_ready"}, {31'd0, split_ready}, 32'd1);
  endtask

  initial begin
    int n;
    int r;
    int target;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;
    @(negedge clk);

    launch_valid = 1; launch_pc = 32'h100; launch_mask = 32'hFFFF_FFFF;
    step();
    idle(3);
    do_update(0, 32'h104, 0, 0); step();
    idle(2);
    do_update(0, 32'h108, 1, 0); step();
    idle(3);
    wb_valid = 1; wb_split_table_num = 2'd0; step();
    idle(2);
    do_split(0, 32'h200, 32'h0000_FFFF); step();
    do_update(0, 32'h10C, 0, 0); step();
    idle(3);

    do_split(0, 32'h300, 32'h00FF_0000); step();
    do_split(0, 32'h400, 32'h0F00_0000); step();
    chk("full_split_ready", {31'd0, split_ready}, 32'd0);
    do_split(0, 32'h500, 32'h1000_0000); step();
    idle(2);

    for (int c = 0; c < 60 && live_count() > 0; c++) begin
      target = -1;
      for (int i = 0; i < NS; i++) if (m_v[i] && m_st[i] == 1) target = i;
      if (target >= 0) do_update(target, 32'h0, 0, 1);
      step();
    end
    chk("all_exited", live_count(), 0);
    idle(2);
    launch_valid = 1; launch_pc = 32'h900; launch_mask = 32'h0000_00FF;
    step();

    step();
    mon_en = 0;
    expq.delete();
    #1 rst_n = 0;
    #1 check_all_zero("midreset");
    model_reset();
    @(posedge clk); #2;
    chk("midreset_no_pulse", {31'd0, select_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    idle(3);

    for (int c = 0; c < 3000; c++) begin
      if (!m_launched || live_count() == 0 || $urandom_range(63) == 0) begin
        launch_valid = 1; launch_pc = $urandom; launch_mask = $urandom | 32'h1;
      end
      if ($urandom_range(3) == 0) begin
        n = int'($urandom_range(NS - 1));
        r = int'($urandom_range(5));
        do_split(n, $urandom, (r == 0) ? 32'h0 : (r == 1) ? m_mask[n] : (m_mask[n] & $urandom));
      end
      if ($urandom_range(1) == 0)
        do_update(int'($urandom_range(NS - 1)), $urandom,
                  $urandom_range(2) == 0, $urandom_range(7) == 0);
      if ($urandom_range(2) == 0) begin
        wb_valid = 1; wb_split_table_num = 2'($urandom_range(NS - 1));
      end
      step();
    end

    @(posedge clk); #3;
    chk("scoreboard_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
